register_bank: RTL and testbench

Parametrised register bank: the general successor to the fixed four-entry segment register file. It provides N registered read ports with write-through bypass, one write port, and one always-visible register tap (the CS-style output). It also has a sequenced dump/load engine that streams the whole bank out, or in, over valid/ready handshakes, used for context save/restore and debug. It sits beside the microcode sequencer and feeds the address-generation and bus-interface paths.

---
 rtl/register_bank_pkg.sv | 27 ++
 rtl/register_bank_seq.sv | 87 ++++++++
 rtl/register_bank.sv | 99 +++++++++
 tb/tb_register_bank.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared types and helpers for register_bank: engine state encoding and byte-enable merge.
package register_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2
    } engine_state_t;

    // Merge is done at a fixed maximum width; callers zero-extend and truncate.
    localparam int unsigned MERGE_W     = 256;
    localparam int unsigned MERGE_BYTES = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]     old_val,
        input logic [MERGE_W-1:0]     new_val,
        input logic [MERGE_BYTES-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < MERGE_BYTES; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/register_bank_seq.sv
// Dump/load stream engine for register_bank: FSM, beat counter and handshakes.
module register_bank_seq
    import register_bank_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dump_start,
    input  logic             load_start,
    input  logic             out_ready,
    input  logic             in_valid,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] count,
    output logic             beat_we_c
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

    engine_state_t state;

    // A load beat writes the bank in the same cycle it is accepted.
    assign beat_we_c = in_ready && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state     <= DUMP;
                        count     <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (load_start) begin
                        state    <= LOAD;
                        count    <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                DUMP: begin
                    if (out_valid && out_ready) begin
                        if (count == LAST) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            count <= IDX_W'(count + 1'b1);
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (count == LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            count <= IDX_W'(count + 1'b1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_bank.sv
// Parametrised register bank with bypassed read ports, a tap, and a dump/load stream engine.
// Optional byte-enable port writes are enabled by defining REGFILE_BYTE_WR_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned TAP_IDX  = 1,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD-1:0][IDX_W-1:0]  rd_sel,
    output logic [NUM_RD-1:0][WIDTH-1:0]  rd_val,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_sel,
    input  logic [WIDTH-1:0]              wr_val,
`ifdef REGFILE_BYTE_WR_EN
    input  logic [WIDTH/8-1:0]            wr_be,
`endif
    output logic [WIDTH-1:0]              tap_val,
    input  logic                          dump_start,
    input  logic                          load_start,
    output logic                          busy,
    output logic                          done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_idx,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             beat_we_c;
    logic             port_we_c;
    logic [WIDTH-1:0] port_val_c;
    logic             bank_we_c;
    logic [IDX_W-1:0] bank_idx_c;
    logic [WIDTH-1:0] bank_val_c;

    register_bank_seq #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .load_start (load_start),
        .out_ready  (out_ready),
        .in_valid   (in_valid),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .count      (out_idx),
        .beat_we_c  (beat_we_c)
    );

    assign port_we_c = wr_en && !busy;

`ifdef REGFILE_BYTE_WR_EN
    assign port_val_c = WIDTH'(byte_merge(MERGE_W'(regs[wr_sel]), MERGE_W'(wr_val),
                                          MERGE_BYTES'(wr_be)));
`else
    assign port_val_c = wr_val;
`endif

    // Port writes and load beats never coincide: port writes are blocked while busy.
    assign bank_we_c  = beat_we_c || port_we_c;
    assign bank_idx_c = beat_we_c ? out_idx : wr_sel;
    assign bank_val_c = beat_we_c ? in_data : port_val_c;

    assign tap_val  = regs[TAP_IDX];
    assign out_data = regs[out_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bank_we_c) begin
            regs[bank_idx_c] <= bank_val_c;
        end
    end

    // Read ports forward the merged write value when they target the register being written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_val <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                if (bank_we_c && (bank_idx_c == rd_sel[p])) rd_val[p] <= bank_val_c;
                else                                       rd_val[p] <= regs[rd_sel[p]];
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank (default parameters), scoreboard-based.
module tb_register_bank;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][1:0] rd_sel;
    logic [1:0][15:0] rd_val;
    logic            wr_en;
    logic [1:0]      wr_sel;
    logic [15:0]     wr_val;
`ifdef REGFILE_BYTE_WR_EN
    logic [1:0]      wr_be;
`endif
    logic [15:0]     tap_val;
    logic            dump_start, load_start;
    logic            busy, done;
    logic            out_valid, out_ready;
    logic [1:0]      out_idx;
    logic [15:0]     out_data;
    logic            in_valid, in_ready;
    logic [15:0]     in_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] model [4];
    logic [15:0] exp0_q [$];
    logic [15:0] exp1_q [$];
    logic [17:0] dump_q [$];

    always #5 clk = ~clk;

    register_bank dut (
        .clk        (clk),
        .reset      (reset),
        .rd_sel     (rd_sel),
        .rd_val     (rd_val),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_val     (wr_val),
`ifdef REGFILE_BYTE_WR_EN
        .wr_be      (wr_be),
`endif
        .tap_val    (tap_val),
        .dump_start (dump_start),
        .load_start (load_start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data)
    );

    task automatic test_reset();
        logic [15:0] e0, e1;
        reset = 1'b1;
        rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_val = '0;
`ifdef REGFILE_BYTE_WR_EN
        wr_be = 2'b11;
`endif
        dump_start = 1'b0; load_start = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, out_valid, in_ready} !== 4'b0000 || tap_val !== 16'h0) begin
            $display("FAIL reset_status: busy/done/ov/ir=%b tap=%h, required 0000 tap=0000",
                     {busy, done, out_valid, in_ready}, tap_val);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            rd_sel[0] = 2'(i); rd_sel[1] = 2'(3 - i);
            exp0_q.push_back(model[i]); exp1_q.push_back(model[3 - i]);
            @(negedge clk);
            e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
            total_cnt++;
            if (rd_val[0] !== e0 || rd_val[1] !== e1) begin
                $display("FAIL reset_read[%0d]: got %h/%h, required %h/%h", i,
                         rd_val[0], rd_val[1], e0, e1);
            end else pass_cnt++;
        end
    endtask

    task automatic test_bypass();
        logic [15:0] e0, e1;
        wr_en = 1'b1; wr_sel = 2'd2; wr_val = 16'h1234;
        rd_sel[0] = 2'd2; rd_sel[1] = 2'd3;
        exp0_q.push_back(16'h1234); exp1_q.push_back(model[3]);
        model[2] = 16'h1234;
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 2'd1; wr_val = 16'h5555;
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        total_cnt++;
        if (rd_val[0] !== e0 || rd_val[1] !== e1) begin
            $display("FAIL bypass: got %h/%h, required %h/%h", rd_val[0], rd_val[1], e0, e1);
        end else pass_cnt++;
        total_cnt++;
        if (tap_val !== 16'h0000) begin
            $display("FAIL tap_before_write: got %h, required 0000", tap_val);
        end else pass_cnt++;
        model[1] = 16'h5555;
        @(negedge clk);
        wr_en = 1'b0;
        total_cnt++;
        if (tap_val !== 16'h5555) begin
            $display("FAIL tap_after_write: got %h, required 5555", tap_val);
        end else pass_cnt++;
    endtask

    task automatic test_load();
        int beat = 0;
        int done_cycle = -1;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL load_start: busy=%b in_ready=%b out_valid=%b, required 1 1 0",
                     busy, in_ready, out_valid);
        end else pass_cnt++;
        in_valid = 1'b1; in_data = 16'hA000;
        for (int c = 1; c <= 20; c++) begin
            if (in_ready && beat < 4) begin model[beat] = in_data; beat++; end
            @(negedge clk);
            in_data = 16'hA000 + 16'(beat);
            if (done) begin done_cycle = c; break; end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (done_cycle != 4 || busy !== 1'b0) begin
            $display("FAIL load_done: done after %0d cycles busy=%b, required 4 cycles busy=0",
                     done_cycle, busy);
        end else pass_cnt++;
        total_cnt++;
        if (tap_val !== 16'hA001) begin
            $display("FAIL load_tap: got %h, required a001", tap_val);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) begin
            $display("FAIL load_done_pulse: done=%b, required 0", done);
        end else pass_cnt++;
    endtask

    task automatic test_dump();
        logic [17:0] e;
        logic        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) dump_q.push_back({2'(i), model[i]});
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = c[0];
            if (out_valid && dump_q.size() > 0) begin
                e = dump_q[0];
                total_cnt++;
                if ({out_idx, out_data} !== e) begin
                    $display("FAIL dump_beat: got idx %0d data %h, required idx %0d data %h",
                             out_idx, out_data, e[17:16], e[15:0]);
                end else pass_cnt++;
                if (out_ready) void'(dump_q.pop_front());
            end
            @(negedge clk);
            if (done) begin saw_done = 1'b1; break; end
        end
        out_ready = 1'b0;
        total_cnt++;
        if (!saw_done || dump_q.size() != 0 || busy !== 1'b0) begin
            $display("FAIL dump_end: done_seen=%b beats_left=%0d busy=%b, required 1 0 0",
                     saw_done, dump_q.size(), busy);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_collision();
        logic [15:0] e0;
        logic        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) dump_q.push_back({2'(i), model[i]});
        dump_start = 1'b1; load_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0; load_start = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL collision_state: out_valid=%b in_ready=%b busy=%b, required 1 0 1",
                     out_valid, in_ready, busy);
        end else pass_cnt++;
        out_ready = 1'b0;
        wr_en = 1'b1; wr_sel = 2'd0; wr_val = 16'hFFFF; rd_sel[0] = 2'd0;
        exp0_q.push_back(model[0]);
        @(negedge clk);
        wr_en = 1'b0;
        e0 = exp0_q.pop_front();
        total_cnt++;
        if (rd_val[0] !== e0) begin
            $display("FAIL blocked_write_bypass: got %h, required %h", rd_val[0], e0);
        end else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && dump_q.size() > 0) begin
                total_cnt++;
                if ({out_idx, out_data} !== dump_q[0]) begin
                    $display("FAIL collision_beat: got idx %0d data %h, required idx %0d data %h",
                             out_idx, out_data, dump_q[0][17:16], dump_q[0][15:0]);
                end else pass_cnt++;
                void'(dump_q.pop_front());
            end
            @(negedge clk);
            if (done) begin saw_done = 1'b1; break; end
        end
        out_ready = 1'b0;
        total_cnt++;
        if (!saw_done || dump_q.size() != 0 || in_ready !== 1'b0) begin
            $display("FAIL collision_end: done_seen=%b beats_left=%0d in_ready=%b, required 1 0 0",
                     saw_done, dump_q.size(), in_ready);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [15:0] e0, e1;
        logic        saw_done = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b1; in_data = 16'hB000;
        @(negedge clk);
        in_data = 16'hB001;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL abort_status: busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (saw_done || tap_val !== 16'h0) begin
            $display("FAIL abort_done: done_seen=%b tap=%h, required 0 0000", saw_done, tap_val);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            rd_sel[0] = 2'(i); rd_sel[1] = 2'(3 - i);
            exp0_q.push_back(model[i]); exp1_q.push_back(model[3 - i]);
            @(negedge clk);
            e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
            total_cnt++;
            if (rd_val[0] !== e0 || rd_val[1] !== e1) begin
                $display("FAIL abort_read[%0d]: got %h/%h, required %h/%h", i,
                         rd_val[0], rd_val[1], e0, e1);
            end else pass_cnt++;
        end
    endtask

`ifdef REGFILE_BYTE_WR_EN
    task automatic test_byte_wr();
        logic [15:0] e0, e1;
        wr_en = 1'b1; wr_sel = 2'd1; wr_val = 16'hBEEF; wr_be = 2'b11;
        @(negedge clk);
        wr_val = 16'h1234; wr_be = 2'b01; rd_sel[0] = 2'd1;
        exp0_q.push_back(16'hBE34);
        @(negedge clk);
        wr_val = 16'hFFFF; wr_be = 2'b00; rd_sel[1] = 2'd1;
        exp1_q.push_back(16'hBE34);
        e0 = exp0_q.pop_front();
        total_cnt++;
        if (rd_val[0] !== e0) begin
            $display("FAIL byte_bypass: got %h, required %h", rd_val[0], e0);
        end else pass_cnt++;
        @(negedge clk);
        wr_en = 1'b0; wr_be = 2'b11;
        e1 = exp1_q.pop_front();
        total_cnt++;
        if (rd_val[1] !== e1 || tap_val !== 16'hBE34) begin
            $display("FAIL byte_zero_be: got %h tap %h, required %h tap be34", rd_val[1], tap_val, e1);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_load();
        test_dump();
        test_collision();
        test_reset_abort();
`ifdef REGFILE_BYTE_WR_EN
        test_byte_wr();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
